// File: rtl/regfile_write_queue.sv
// regfile_write_queue: buffers late register results and drains them into the
// register file write port whenever primary writeback leaves it free.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [AW-1:0] i_in_reg,
  input  logic [DW-1:0] i_in_data,
  input  logic          i_port_busy,
  output logic [AW-1:0] o_w,
  output logic [DW-1:0] o_din,
  output logic          o_we,
  input  logic [AW-1:0] i_query_reg1,
  input  logic [AW-1:0] i_query_reg2,
  output logic          o_pending1,
  output logic          o_pending2,
  output logic [AW-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    r_reg  [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_rd, r_wr;
  logic [AW-1:0]    r_count;
  logic             w_pop, w_push;

  assign w_pop      = (r_count != '0) & ~i_port_busy;
  assign o_in_ready = (r_count < AW'(DEPTH)) | w_pop;
  // Writes to r0 are acknowledged but dropped: r0 is hardwired zero.
  assign w_push     = i_in_valid & o_in_ready & (i_in_reg != '0);
  assign o_we       = w_pop;
  assign o_w        = r_reg[r_rd];
  assign o_din      = r_data[r_rd];
  assign o_count    = r_count;

  always_comb begin
    o_pending1 = 1'b0;
    o_pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_pending1 = o_pending1 | (r_valid[i] & (r_reg[i] == i_query_reg1));
      o_pending2 = o_pending2 | (r_valid[i] & (r_reg[i] == i_query_reg2));
    end
    o_pending1 = o_pending1 & (i_query_reg1 != '0);
    o_pending2 = o_pending2 & (i_query_reg2 != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd] <= 1'b0;
        r_rd          <= r_rd + PW'(1);
      end
      // Set after clear so a full-queue push+pop on the same slot stays valid.
      if (w_push) begin
        r_valid[r_wr] <= 1'b1;
        r_wr          <= r_wr + PW'(1);
      end
      r_count <= r_count + AW'(w_push) - AW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_reg[r_wr]  <= i_in_reg;
      r_data[r_wr] <= i_in_data;
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and random stimulus checked every cycle
// against a queue-based model of the write buffer.
module tb_regfile_write_queue;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, port_busy = 1'b0, we, p1, p2;
  logic [4:0]  in_reg = '0, w, q1 = '0, q2 = '0, cnt;
  logic [31:0] in_data = '0, din;
  int          checks = 0, passes = 0;
  logic [4:0]  mr[$];
  logic [31:0] md[$];

  regfile_write_queue dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_reg(in_reg), .i_in_data(in_data), .i_port_busy(port_busy),
    .o_w(w), .o_din(din), .o_we(we), .i_query_reg1(q1), .i_query_reg2(q2),
    .o_pending1(p1), .o_pending2(p2), .o_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr.delete();
      md.delete();
    end else begin
      automatic bit pop  = mr.size() != 0 && !port_busy;
      automatic bit push = in_valid && (mr.size() < 4 || pop) && in_reg != 0;
      if (pop) begin
        void'(mr.pop_front());
        void'(md.pop_front());
      end
      if (push) begin
        mr.push_back(in_reg);
        md.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    automatic int n = mr.size();
    automatic bit pop = n != 0 && !port_busy;
    automatic bit e1 = 0, e2 = 0;
    foreach (mr[i]) begin
      if (mr[i] == q1) e1 = 1;
      if (mr[i] == q2) e2 = 1;
    end
    chk("m_we", 32'(we), 32'(pop));
    chk("m_ready", 32'(in_ready), 32'(n < 4 || pop));
    chk("m_count", 32'(cnt), 32'(n));
    chk("m_pend1", 32'(p1), 32'(e1 && q1 != 0));
    chk("m_pend2", 32'(p2), 32'(e2 && q2 != 0));
    if (n != 0) begin
      chk("m_w", 32'(w), 32'(mr[0]));
      chk("m_din", din, md[0]);
    end
  end

  task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d, input logic b);
    in_valid = v; in_reg = r; in_data = d; port_busy = b;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] seq [4];
    seq[0] = 5'd2; seq[1] = 5'd3; seq[2] = 5'd5; seq[3] = 5'd7;
    in_valid = 1'b1; in_reg = 5'd3; q1 = 5'd3; q2 = 5'd3;
    #2;
    chk("rst_we", 32'(we), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_pend", 32'({p1, p2}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; q1 = '0; q2 = '0;
    // single write
    step(1'b1, 5'd4, 32'hAA, 1'b0);
    in_valid = 1'b0; #2;
    chk("single_we", 32'(we), 1);
    chk("single_w", 32'(w), 4);
    chk("single_din", din, 32'hAA);
    @(posedge clk); #3;
    chk("single_cnt", 32'(cnt), 0);
    chk("single_we0", 32'(we), 0);
    // fill while port busy
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], $urandom, 1'b1);
    in_valid = 1'b1; in_reg = 5'd11; #2;
    chk("fill_cnt", 32'(cnt), 4);
    chk("fill_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; port_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("drain_we", 32'(we), 1);
      chk("drain_w", 32'(w), 32'(seq[i]));
      @(posedge clk); #1;
    end
    chk("drain_cnt", 32'(cnt), 0);
    // push while full and draining
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], $urandom, 1'b1);
    in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h99; port_busy = 1'b0; #2;
    chk("full_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; #2;
    chk("full_cnt", 32'(cnt), 4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        chk("full_w9", 32'(w), 9);
        chk("full_d9", din, 32'h99);
      end
      @(posedge clk); #3;
    end
    // r0 offer and hazard query
    step(1'b1, 5'd0, 32'h1234, 1'b0);
    in_valid = 1'b0; #2;
    chk("zero_cnt", 32'(cnt), 0);
    chk("zero_we", 32'(we), 0);
    @(posedge clk); #1;
    step(1'b1, 5'd8, 32'h88, 1'b1);
    in_valid = 1'b0; q1 = 5'd8; q2 = 5'd0; #2;
    chk("haz_p1", 32'(p1), 1);
    chk("haz_p2", 32'(p2), 0);
    port_busy = 1'b0;
    @(posedge clk); #3;
    chk("haz_p1_clr", 32'(p1), 0);
    q1 = '0;
    // async reset mid-cycle
    for (int i = 0; i < 3; i++) step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
    in_valid = 1'b0; port_busy = 1'b0; #2;
    chk("ar_we_pre", 32'(we), 1);
    rst_n = 1'b0; #1;
    chk("ar_we", 32'(we), 0);
    chk("ar_cnt", 32'(cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 1'b0);
    chk("ar_after", 32'({we, cnt}), 0);
    // random traffic with duplicate destinations
    for (int i = 0; i < 400; i++) begin
      q1 = 5'($urandom_range(0, 7));
      q2 = 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 7)));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
